// File: rtl/ks_flag_unit_pkg.sv
// Shared definitions for the ones'-complement result-flag unit:
// FSM state encoding and width-generic constant helpers.
package ks_flag_unit_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FIX   = 2'd2,
    ST_DONE  = 2'd3
  } ks_state_e;

  // Low w bits set; callers cast the result down to their own width.
  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    if (w >= MAX_W) begin
      all_ones = {MAX_W{1'b1}};
    end else begin
      all_ones = (64'd1 << w) - 64'd1;
    end
  endfunction

  function automatic logic [MAX_W-1:0] zero(input int unsigned w);
    zero = (w == 32'd0) ? {MAX_W{1'b0}} : {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/ks_flag_unit_nz_detect.sv
// Combinational classifier of an (N+1)-bit ones'-complement value:
// -0 (all ones), +0 (all zeros) and the sign bit.
module ks_nz_detect
  import ks_flag_unit_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N:0] q,
  output logic       is_nz,
  output logic       is_pz,
  output logic       sign
);

  localparam logic [N:0] Q_ALL_ONES = (N+1)'(all_ones(N+1));
  localparam logic [N:0] Q_ZERO     = (N+1)'(zero(N+1));

  assign is_nz = (q == Q_ALL_ONES);
  assign is_pz = (q == Q_ZERO);
  assign sign  = q[N];

endmodule

// File: rtl/ks_flag_unit.sv
// Registered result-flag unit: captures the result register, classifies it,
// optionally folds -0 into +0 and tracks -0 events in a sticky flag and counter.
module ks_flag_unit
  import ks_flag_unit_pkg::*;
#(
  parameter int N       = 4,
  parameter int NORM_NZ = 1,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N:0]    rr,
  input  logic          ld,
  input  logic          clr_sticky,
  output logic          rdy,
  output logic          vld,
  output logic [N:0]    rr_out,
  output logic          fz,
  output logic          fnz,
  output logic          fs,
  output logic          sticky_nz,
  output logic [CW-1:0] nz_cnt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(all_ones(CW));
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [N:0]    Q_ZERO  = (N+1)'(zero(N+1));

  ks_state_e     state_r;
  ks_state_e     state_nxt_s;
  logic [N:0]    q_r;
  logic          is_nz_s;
  logic          is_pz_s;
  logic          sign_s;
  logic          chk_nz_s;
  logic [N:0]    rr_out_r;
  logic          fz_r;
  logic          fnz_r;
  logic          fs_r;
  logic          sticky_r;
  logic [CW-1:0] cnt_r;
  logic          rdy_r;
  logic          vld_r;

  ks_nz_detect #(.N(N)) u_detect (
    .q     (q_r),
    .is_nz (is_nz_s),
    .is_pz (is_pz_s),
    .sign  (sign_s)
  );

  assign chk_nz_s = (state_r == ST_CHECK) && is_nz_s;

  // Next-state logic; ld outside IDLE is simply not looked at.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (is_nz_s && (NORM_NZ != 0)) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_FIX:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with rdy/vld registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b1;
      vld_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rdy_r   <= (state_nxt_s == ST_IDLE);
      vld_r   <= (state_nxt_s == ST_DONE);
    end
  end

  // Capture rr only on an accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= Q_ZERO;
    end else if ((state_r == ST_IDLE) && ld) begin
      q_r <= rr;
    end else begin
      q_r <= q_r;
    end
  end

  // Result and flags move only in CHECK and FIX; fnz is left set by FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_out_r <= Q_ZERO;
      fz_r     <= 1'b0;
      fnz_r    <= 1'b0;
      fs_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_CHECK: begin
          rr_out_r <= q_r;
          fz_r     <= is_pz_s;
          fnz_r    <= is_nz_s;
          fs_r     <= sign_s;
        end
        ST_FIX: begin
          rr_out_r <= Q_ZERO;
          fz_r     <= 1'b1;
          fs_r     <= 1'b0;
        end
        default: begin
          rr_out_r <= rr_out_r;
        end
      endcase
    end
  end

  // Sticky -0 flag and saturating counter; a detection beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (chk_nz_s) begin
      sticky_r <= 1'b1;
      if (clr_sticky) begin
        cnt_r <= CNT_ONE;
      end else if (cnt_r == CNT_MAX) begin
        cnt_r <= cnt_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if (clr_sticky) begin
      sticky_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign rdy       = rdy_r;
  assign vld       = vld_r;
  assign rr_out    = rr_out_r;
  assign fz        = fz_r;
  assign fnz       = fnz_r;
  assign fs        = fs_r;
  assign sticky_nz = sticky_r;
  assign nz_cnt    = cnt_r;

endmodule

// File: tb/tb_ks_flag_unit.sv
// Self-checking bench for ks_flag_unit: instance a normalises -0 (CW=4),
// instance b passes -0 through (CW=2); expectations flow through a scoreboard queue.
module tb_ks_flag_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ld_a, clr_a, rdy_a, vld_a, fz_a, fnz_a, fs_a, sticky_a;
  logic [4:0] rr_a, rr_out_a;
  logic [3:0] cnt_a;
  logic       rst_b, ld_b, clr_b, rdy_b, vld_b, fz_b, fnz_b, fs_b, sticky_b;
  logic [4:0] rr_b, rr_out_b;
  logic [1:0] cnt_b;

  ks_flag_unit #(.N(4), .NORM_NZ(1), .CW(4)) u_a (
    .clk(clk), .rst_n(rst_a), .rr(rr_a), .ld(ld_a), .clr_sticky(clr_a),
    .rdy(rdy_a), .vld(vld_a), .rr_out(rr_out_a), .fz(fz_a), .fnz(fnz_a),
    .fs(fs_a), .sticky_nz(sticky_a), .nz_cnt(cnt_a)
  );

  ks_flag_unit #(.N(4), .NORM_NZ(0), .CW(2)) u_b (
    .clk(clk), .rst_n(rst_b), .rr(rr_b), .ld(ld_b), .clr_sticky(clr_b),
    .rdy(rdy_b), .vld(vld_b), .rr_out(rr_out_b), .fz(fz_b), .fnz(fnz_b),
    .fs(fs_b), .sticky_nz(sticky_b), .nz_cnt(cnt_b)
  );

  typedef struct {
    logic [4:0] rr;
    logic       fz;
    logic       fnz;
    logic       fs;
    int         lat;
    logic       sticky;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic sticky_m[2];
  int   cnt_m[2];

  task automatic drive(input bit b, input logic l, input logic [4:0] v, input logic c);
    if (b) begin
      ld_b = l; rr_b = v; clr_b = c;
    end else begin
      ld_a = l; rr_a = v; clr_a = c;
    end
  endtask

  // One load: push the model's expectation, run it, pop and compare on vld.
  task automatic txn(input bit b, input logic [4:0] v, input bit clr_at_check,
                     input bit extra_ld, input string nm);
    exp_t e;
    exp_t g;
    bit   nz, fixm, seen;
    int   lat, cmax, cnt_o;
    nz   = (v == 5'h1f);
    fixm = nz && !b;
    cmax = b ? 3 : 15;
    e.rr  = fixm ? 5'd0 : v;
    e.fz  = (v == 5'd0) || fixm;
    e.fnz = nz;
    e.fs  = fixm ? 1'b0 : v[4];
    e.lat = fixm ? 3 : 2;
    if (nz) begin
      sticky_m[b] = 1'b1;
      cnt_m[b] = clr_at_check ? 1 : ((cnt_m[b] == cmax) ? cmax : cnt_m[b] + 1);
    end
    e.sticky = sticky_m[b];
    e.cnt    = cnt_m[b];
    sb.push_back(e);

    @(negedge clk);
    drive(b, 1'b1, v, 1'b0);
    @(negedge clk);
    drive(b, extra_ld, ~v, clr_at_check);
    lat  = 1;
    seen = 1'b0;
    while (lat < 8 && !seen) begin
      if (b ? vld_b : vld_a) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        drive(b, 1'b0, ~v, 1'b0);
        lat++;
      end
    end
    g = sb.pop_front();
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s timeout: no vld within %0d cycles", nm, lat);
    end else begin
      cnt_o = b ? int'(cnt_b) : int'(cnt_a);
      if ((b ? rr_out_b : rr_out_a) !== g.rr || (b ? fz_b : fz_a) !== g.fz ||
          (b ? fnz_b : fnz_a) !== g.fnz || (b ? fs_b : fs_a) !== g.fs) begin
        n_errors++;
        $display("FAIL %s result: rr_out=%b fz=%b fnz=%b fs=%b, expected %b %b %b %b", nm,
                 b ? rr_out_b : rr_out_a, b ? fz_b : fz_a, b ? fnz_b : fnz_a,
                 b ? fs_b : fs_a, g.rr, g.fz, g.fnz, g.fs);
      end
      n_checks++;
      if (lat !== g.lat) begin
        n_errors++;
        $display("FAIL %s latency: got %0d expected %0d", nm, lat, g.lat);
      end
      n_checks++;
      if ((b ? sticky_b : sticky_a) !== g.sticky || cnt_o !== g.cnt) begin
        n_errors++;
        $display("FAIL %s sticky/cnt: got %b/%0d expected %b/%0d", nm,
                 b ? sticky_b : sticky_a, cnt_o, g.sticky, g.cnt);
      end
    end
    @(negedge clk);
    drive(b, 1'b0, ~v, 1'b0);
    n_checks++;
    if ((b ? vld_b : vld_a) !== 1'b0 || (b ? rdy_b : rdy_a) !== 1'b1) begin
      n_errors++;
      $display("FAIL %s after_done: vld=%b rdy=%b expected 0 1", nm,
               b ? vld_b : vld_a, b ? rdy_b : rdy_a);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rdy_a, vld_a, rr_out_a, fz_a, fnz_a, fs_a, sticky_a, cnt_a} !== {1'b1, 14'd0}) begin
      n_errors++;
      $display("FAIL reset_a: rdy=%b vld=%b rr_out=%b fz=%b fnz=%b fs=%b sticky=%b cnt=%0d expected 1 then zeros",
               rdy_a, vld_a, rr_out_a, fz_a, fnz_a, fs_a, sticky_a, cnt_a);
    end
    n_checks++;
    if ({rdy_b, vld_b, rr_out_b, fz_b, fnz_b, fs_b, sticky_b, cnt_b} !== {1'b1, 12'd0}) begin
      n_errors++;
      $display("FAIL reset_b: rdy=%b vld=%b rr_out=%b cnt=%0d expected 1 0 0 0", rdy_b, vld_b, rr_out_b, cnt_b);
    end
    sticky_m[0] = 1'b0; sticky_m[1] = 1'b0; cnt_m[0] = 0; cnt_m[1] = 0;
  endtask

  task automatic test_pos_zero();
    txn(1'b0, 5'b00000, 1'b0, 1'b0, "pos_zero");
  endtask

  task automatic test_neg_zero_norm();
    txn(1'b0, 5'b11111, 1'b0, 1'b0, "neg_zero_norm");
  endtask

  // Sign value with an ignored ld during CHECK; results then hold while idle.
  task automatic test_sign_ignored_ld();
    int extra;
    txn(1'b0, 5'b10110, 1'b0, 1'b1, "sign_value");
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vld_a) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_errors++;
      $display("FAIL ignored_ld: extra vld pulses=%0d expected 0", extra);
    end
    n_checks++;
    if (rr_out_a !== 5'b10110 || fs_a !== 1'b1 || fz_a !== 1'b0 || fnz_a !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_after_vld: rr_out=%b fs=%b fz=%b fnz=%b expected 10110 1 0 0",
               rr_out_a, fs_a, fz_a, fnz_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      txn(1'b1, 5'b11111, 1'b0, 1'b0, "nz_saturate");
    end
  endtask

  task automatic test_clr_idle();
    @(negedge clk);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    sticky_m[1] = 1'b0; cnt_m[1] = 0;
    n_checks++;
    if (sticky_b !== 1'b0 || cnt_b !== 2'd0) begin
      n_errors++;
      $display("FAIL clr_idle: sticky=%b cnt=%0d expected 0 0", sticky_b, cnt_b);
    end
  endtask

  task automatic test_clr_collision();
    txn(1'b1, 5'b11111, 1'b0, 1'b0, "pre_collision");
    txn(1'b1, 5'b11111, 1'b0, 1'b0, "pre_collision");
    txn(1'b1, 5'b11111, 1'b1, 1'b0, "clr_collision");
  endtask

  // Reset asserted while instance a sits in FIX for a -0 load.
  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    drive(1'b0, 1'b1, 5'b11111, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'b00000, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    n_checks++;
    if ({rdy_a, vld_a, rr_out_a, fz_a, fnz_a, fs_a, sticky_a, cnt_a} !== {1'b1, 14'd0}) begin
      n_errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b rr_out=%b fz=%b fnz=%b fs=%b sticky=%b cnt=%0d expected 1 then zeros",
               rdy_a, vld_a, rr_out_a, fz_a, fnz_a, fs_a, sticky_a, cnt_a);
    end
    @(negedge clk);
    rst_a = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld_a) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || rdy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_release: vld pulses=%0d rdy=%b expected 0 1", pulses, rdy_a);
    end
  endtask

  initial begin
    test_reset();
    test_pos_zero();
    test_neg_zero_norm();
    test_sign_ignored_ld();
    test_saturation();
    test_clr_idle();
    test_clr_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
